// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main control sequencer of the multi-cycle RV32I core. Walks every
//   instruction through fetch/decode/execute/memory/writeback, steers the
//   ALU operand muxes, handshakes with the single shared memory port and
//   resolves BEQ/BNE from the ALU Zero flag. Unsupported opcodes and branch
//   funct3 values park the machine in a sticky TRAP state until reset.
//
//   Optional feature: define MEM_TIMEOUT_EN to bound every memory wait to
//   MEM_TIMEOUT cycles (an expired wait traps). Without the macro the FSM
//   waits on MemReady indefinitely and MEM_TIMEOUT has no effect.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Run,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       ResultSrc,
  output logic       InstrDone,
  output logic       Busy,
  output logic       Trap
);

  // Opcode map of the supported instruction classes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RI  = 2'b10;

  // ALU operand B select encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_ALU  = 4'd3,
    S_WB_ALU    = 4'd4,
    S_EXEC_ADDR = 4'd5,
    S_MEM_RD    = 4'd6,
    S_MEM_WR    = 4'd7,
    S_WB_MEM    = 4'd8,
    S_EXEC_BR   = 4'd9,
    S_TRAP      = 4'd10
  } state_e;

  state_e state_q, state_d;

  // A memory access is waiting whenever an access state sees no MemReady
  logic mem_state;
  logic mem_wait;
  logic timeout_hit;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
  assign mem_wait  = mem_state && !MemReady;

`ifdef MEM_TIMEOUT_EN
  // Wait counter: number of stalled cycles spent on the current access.
  // It returns to zero whenever the FSM is not stalled, so every access
  // state is entered with a clean count.
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Next wait count: increment while stalled, otherwise clear
  always_comb begin
    wait_cnt_d = 8'd0;
    if (mem_wait) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The stall that would bring the count to MEM_TIMEOUT traps; a MemReady
  // arriving on that same cycle is not a stall and therefore wins.
  assign timeout_hit = mem_wait && (wait_cnt_q == 8'(MEM_TIMEOUT - 1));
`else
  // No watchdog: waits are unbounded and the limit parameter is inert
  logic [7:0] unused_timeout_limit;
  assign unused_timeout_limit = 8'(MEM_TIMEOUT);
  assign timeout_hit          = 1'b0;
`endif

  // Where to go after the last cycle of a retired instruction
  function automatic state_e boundary_next(input logic run);
    return run ? S_FETCH : S_IDLE;
  endfunction

  // State register; async reset lands in IDLE so every output drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode (Mealy terms on MemReady and Zero)
  always_comb begin
    state_d   = state_q;
    ALUOp     = ALUOP_ADD;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RS2;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    InstrDone = 1'b0;
    Busy      = (state_q != S_IDLE) && (state_q != S_TRAP);
    Trap      = (state_q == S_TRAP);

    case (state_q)
      S_IDLE: begin
        if (Run) begin
          state_d = S_FETCH;
        end
      end

      // Instruction read from PC while the ALU forms PC+4
      S_FETCH: begin
        MemReq  = 1'b1;
        IorD    = 1'b0;
        ALUSrcA = 1'b0;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALUOP_ADD;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = 1'b0;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end

      S_DECODE: begin
        case (Opcode)
          OP_R, OP_I_ALU:    state_d = S_EXEC_ALU;
          OP_LOAD, OP_STORE: state_d = S_EXEC_ADDR;
          OP_BRANCH:         state_d = S_EXEC_BR;
          default:           state_d = S_TRAP;
        endcase
      end

      // Register-register uses rs2, register-immediate uses the immediate
      S_EXEC_ALU: begin
        ALUOp   = ALUOP_RI;
        ALUSrcA = 1'b1;
        ALUSrcB = (Opcode == OP_R) ? SRCB_RS2 : SRCB_IMM;
        state_d = S_WB_ALU;
      end

      S_WB_ALU: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b0;
        InstrDone = 1'b1;
        state_d   = boundary_next(Run);
      end

      // Effective address rs1 + imm for both loads and stores
      S_EXEC_ADDR: begin
        ALUOp   = ALUOP_ADD;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) begin
          state_d = S_WB_MEM;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end

      S_WB_MEM: begin
        RegWrite  = 1'b1;
        ResultSrc = 1'b1;
        InstrDone = 1'b1;
        state_d   = boundary_next(Run);
      end

      // A store retires on the cycle memory accepts it
      S_MEM_WR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          InstrDone = 1'b1;
          state_d   = boundary_next(Run);
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end

      // rs1 - rs2 drives Zero this cycle; only BEQ/BNE are legal
      S_EXEC_BR: begin
        ALUOp   = ALUOP_BR;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RS2;
        case (Funct3)
          F3_BEQ: begin
            PCWrite   = Zero;
            PCSrc     = Zero;
            InstrDone = 1'b1;
            state_d   = boundary_next(Run);
          end
          F3_BNE: begin
            PCWrite   = !Zero;
            PCSrc     = !Zero;
            InstrDone = 1'b1;
            state_d   = boundary_next(Run);
          end
          default: begin
            state_d = S_TRAP;
          end
        endcase
      end

      // Sticky; only reset leaves this state
      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scoreboard bench for multicycle_control_fsm. The stimulus process
// drives one cycle at a time and queues the hand-written output vector that
// cycle must show; the monitor pops and compares on every falling edge.
// Build with +define+MEM_TIMEOUT_EN to add the watchdog scenarios.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Run;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Zero;
  logic       MemReady;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSrc;
  logic       RegWrite, ResultSrc, InstrDone, Busy, Trap;

  multicycle_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Run(Run), .Opcode(Opcode), .Funct3(Funct3),
    .Zero(Zero), .MemReady(MemReady), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .InstrDone(InstrDone), .Busy(Busy), .Trap(Trap)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;

  // Vector layout: {ALUOp[1:0], ALUSrcA, ALUSrcB[1:0], MemReq, MemWrite,
  //                 IorD, IRWrite, PCWrite, PCSrc, RegWrite, ResultSrc,
  //                 InstrDone, Busy, Trap}
  //                        op    A     B     Rq    Wr    IoD   IRW   PCW   PCS   RW    RS    Done  Busy  Trap
  localparam logic [15:0] X_IDLE    = {2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [15:0] X_FETCH_W = {2'b00,1'b0,2'b01,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_FETCH_R = {2'b00,1'b0,2'b01,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_DECODE  = {2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_EXR     = {2'b10,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_EXI     = {2'b10,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_WBALU   = {2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
  localparam logic [15:0] X_EXA     = {2'b00,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_MEMRD   = {2'b00,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_WBMEM   = {2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0};
  localparam logic [15:0] X_MEMWR_W = {2'b00,1'b0,2'b00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_MEMWR_R = {2'b00,1'b0,2'b00,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [15:0] X_BR_T    = {2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [15:0] X_BR_N    = {2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [15:0] X_BR_ILL  = {2'b01,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] X_TRAP    = {2'b00,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

  typedef struct {
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  logic [15:0] got;
  assign got = {ALUOp, ALUSrcA, ALUSrcB, MemReq, MemWrite, IorD, IRWrite,
                PCWrite, PCSrc, RegWrite, ResultSrc, InstrDone, Busy, Trap};

  // Monitor: compare the queued expectation against the settled outputs
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      checks++;
      if (got !== it.exp) begin
        errors++;
        $display("FAIL %s: got %b required %b", it.name, got, it.exp);
      end
    end
  end

  // One clock cycle of stimulus plus its expected output vector
  task automatic cyc(input logic run, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic mr, input logic [15:0] e,
                     input string nm);
    item_t it;
    Run      = run;
    Opcode   = op;
    Funct3   = f3;
    Zero     = z;
    MemReady = mr;
    it.exp   = e;
    it.name  = nm;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; Run = 1'b0; Opcode = 7'd0; Funct3 = 3'd0; Zero = 1'b0; MemReady = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 7'd0, 3'd0, 0, 1, X_IDLE, "reset_idle");
    rst_n = 1'b1;
    cyc(0, 7'd0, 3'd0, 0, 1, X_IDLE, "idle_run0");

    // ADD back-to-back into ADDI, then Run=0 at writeback
    cyc(1, ADD, 3'd0, 0, 1, X_IDLE,    "add_idle_run1");
    cyc(1, ADD, 3'd0, 0, 1, X_FETCH_R, "add_fetch");
    cyc(1, ADD, 3'd0, 0, 1, X_DECODE,  "add_decode");
    cyc(1, ADD, 3'd0, 0, 1, X_EXR,     "add_exec");
    cyc(1, ADD, 3'd0, 0, 1, X_WBALU,   "add_wb_done");
    cyc(1, ADDI, 3'd0, 0, 1, X_FETCH_R, "addi_fetch");
    cyc(0, ADDI, 3'd0, 0, 1, X_DECODE,  "addi_decode_run0");
    cyc(0, ADDI, 3'd0, 0, 1, X_EXI,     "addi_exec");
    cyc(0, ADDI, 3'd0, 0, 1, X_WBALU,   "addi_wb_done");
    cyc(0, ADDI, 3'd0, 0, 1, X_IDLE,    "idle_after_run0");
    cyc(0, ADDI, 3'd0, 0, 1, X_IDLE,    "idle_no_memreq");

    // LW with three stalled cycles in MEM_RD
    cyc(1, LW, 3'd2, 0, 0, X_IDLE,    "lw_idle_run1");
    cyc(1, LW, 3'd2, 0, 1, X_FETCH_R, "lw_fetch");
    cyc(1, LW, 3'd2, 0, 0, X_DECODE,  "lw_decode");
    cyc(1, LW, 3'd2, 0, 0, X_EXA,     "lw_exec_addr");
    for (int i = 0; i < 3; i++) cyc(1, LW, 3'd2, 0, 0, X_MEMRD, "lw_memrd_wait");
    cyc(1, LW, 3'd2, 0, 1, X_MEMRD,   "lw_memrd_ready");
    cyc(1, LW, 3'd2, 0, 0, X_WBMEM,   "lw_wb_mem");

    // SW with one fetch stall and one write stall
    cyc(1, SW, 3'd2, 0, 0, X_FETCH_W, "sw_fetch_wait");
    cyc(1, SW, 3'd2, 0, 1, X_FETCH_R, "sw_fetch");
    cyc(1, SW, 3'd2, 0, 1, X_DECODE,  "sw_decode");
    cyc(1, SW, 3'd2, 0, 1, X_EXA,     "sw_exec_addr");
    cyc(1, SW, 3'd2, 0, 0, X_MEMWR_W, "sw_memwr_wait");
    cyc(1, SW, 3'd2, 0, 1, X_MEMWR_R, "sw_memwr_done");

    // BEQ/BNE with both Zero values
    cyc(1, BR, 3'd0, 1, 1, X_FETCH_R, "beq_fetch");
    cyc(1, BR, 3'd0, 1, 1, X_DECODE,  "beq_decode");
    cyc(1, BR, 3'd0, 1, 1, X_BR_T,    "beq_zero1_taken");
    cyc(1, BR, 3'd0, 0, 1, X_FETCH_R, "beq2_fetch");
    cyc(1, BR, 3'd0, 0, 1, X_DECODE,  "beq2_decode");
    cyc(1, BR, 3'd0, 0, 1, X_BR_N,    "beq_zero0_not_taken");
    cyc(1, BR, 3'd1, 1, 1, X_FETCH_R, "bne_fetch");
    cyc(1, BR, 3'd1, 1, 1, X_DECODE,  "bne_decode");
    cyc(1, BR, 3'd1, 1, 1, X_BR_N,    "bne_zero1_not_taken");
    cyc(1, BR, 3'd1, 0, 1, X_FETCH_R, "bne2_fetch");
    cyc(1, BR, 3'd1, 0, 1, X_DECODE,  "bne2_decode");
    cyc(1, BR, 3'd1, 0, 1, X_BR_T,    "bne_zero0_taken");

    // Asynchronous reset in the middle of a stalled load
    cyc(1, LW, 3'd2, 0, 1, X_FETCH_R, "lw2_fetch");
    cyc(1, LW, 3'd2, 0, 1, X_DECODE,  "lw2_decode");
    cyc(1, LW, 3'd2, 0, 0, X_EXA,     "lw2_exec_addr");
    cyc(1, LW, 3'd2, 0, 0, X_MEMRD,   "lw2_memrd_pre_reset");
    rst_n = 1'b0;
    cyc(1, LW, 3'd2, 0, 0, X_IDLE,    "reset_mid_memrd");
    cyc(1, LW, 3'd2, 0, 1, X_IDLE,    "reset_held");
    rst_n = 1'b1;
    cyc(0, LW, 3'd2, 0, 1, X_IDLE,    "reset_released_idle");
    cyc(0, LW, 3'd2, 0, 1, X_IDLE,    "idle_after_reset");

    // Illegal branch funct3 traps and stays trapped
    cyc(1, BR, 3'd4, 1, 1, X_IDLE,    "bad_br_idle_run1");
    cyc(1, BR, 3'd4, 1, 1, X_FETCH_R, "bad_br_fetch");
    cyc(1, BR, 3'd4, 1, 1, X_DECODE,  "bad_br_decode");
    cyc(1, BR, 3'd4, 1, 1, X_BR_ILL,  "bad_br_exec");
    for (int i = 0; i < 3; i++) cyc(1, BR, 3'd4, 1, 1, X_TRAP, "bad_br_trap_sticky");

    // Unsupported opcode traps right after DECODE
    rst_n = 1'b0;
    cyc(1, JAL, 3'd0, 0, 1, X_IDLE,   "reset_from_trap");
    rst_n = 1'b1;
    cyc(1, JAL, 3'd0, 0, 1, X_IDLE,   "jal_idle_run1");
    cyc(1, JAL, 3'd0, 0, 1, X_FETCH_R, "jal_fetch");
    cyc(1, JAL, 3'd0, 0, 1, X_DECODE, "jal_decode");
    cyc(1, JAL, 3'd0, 0, 1, X_TRAP,   "jal_trap");
    cyc(0, JAL, 3'd0, 0, 1, X_TRAP,   "jal_trap_sticky");

`ifdef MEM_TIMEOUT_EN
    // Sixteen stalled fetch cycles trap on the next cycle
    rst_n = 1'b0;
    cyc(1, ADD, 3'd0, 0, 0, X_IDLE, "to_reset");
    rst_n = 1'b1;
    cyc(1, ADD, 3'd0, 0, 0, X_IDLE, "to_idle_run1");
    for (int i = 0; i < 16; i++) cyc(1, ADD, 3'd0, 0, 0, X_FETCH_W, "to_fetch_wait");
    cyc(1, ADD, 3'd0, 0, 0, X_TRAP, "to_trap");
    // MemReady on the limit cycle beats the timeout
    rst_n = 1'b0;
    cyc(1, ADD, 3'd0, 0, 0, X_IDLE, "to2_reset");
    rst_n = 1'b1;
    cyc(1, ADD, 3'd0, 0, 0, X_IDLE, "to2_idle_run1");
    for (int i = 0; i < 15; i++) cyc(1, ADD, 3'd0, 0, 0, X_FETCH_W, "to2_fetch_wait");
    cyc(1, ADD, 3'd0, 0, 1, X_FETCH_R, "to2_ready_on_limit");
    cyc(1, ADD, 3'd0, 0, 1, X_DECODE,  "to2_decode");
`endif

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
